// File: rtl/fill_run_encoder.sv
//------------------------------------------------------------------------------
// Module  : fill_run_encoder
// Brief   : Classifies words into fill tokens (ZERO/ONES/ZEXT/SEXT/LIT) and
//           run-length merges consecutive all-zeros / all-ones words.
//           Optional macro FILL_RUN_ENCODER_STATS_EN adds word/token counters.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fill_run_encoder #(
  parameter int WIDTH  = 40,
  parameter int NARROW = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_kind,
  output logic [CNT_W-1:0]  out_count,
  output logic [NARROW-1:0] out_data,
  output logic [WIDTH-1:0]  out_lit
`ifdef FILL_RUN_ENCODER_STATS_EN
  ,
  output logic [31:0]       stat_words,
  output logic [31:0]       stat_tokens
`endif
);

  localparam logic [2:0] c_kind_zero = 3'd0;
  localparam logic [2:0] c_kind_ones = 3'd1;
  localparam logic [2:0] c_kind_zext = 3'd2;
  localparam logic [2:0] c_kind_sext = 3'd3;
  localparam logic [2:0] c_kind_lit  = 3'd4;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_pend = 2'd2;

  localparam logic [CNT_W-1:0] c_rmax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_one  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]        r_state, w_state_nxt;
  logic [2:0]        r_run_kind;
  logic [CNT_W-1:0]  r_run_cnt;
  logic [2:0]        r_pend_kind;
  logic [NARROW-1:0] r_pend_data;
  logic [WIDTH-1:0]  r_pend_lit;

  logic              r_out_valid;
  logic [2:0]        r_out_kind;
  logic [CNT_W-1:0]  r_out_count;
  logic [NARROW-1:0] r_out_data;
  logic [WIDTH-1:0]  r_out_lit;

  logic [2:0]        w_kind;
  logic              w_is_fill;
  logic [NARROW-1:0] w_word_data;
  logic [WIDTH-1:0]  w_word_lit;
  logic              w_f;
  logic              w_accept;
  logic              w_same;
  logic [CNT_W-1:0]  w_cnt_inc;

  logic              w_emit;
  logic [2:0]        w_tok_kind;
  logic [CNT_W-1:0]  w_tok_cnt;
  logic [NARROW-1:0] w_tok_data;
  logic [WIDTH-1:0]  w_tok_lit;
  logic              w_pend_load;
  logic              w_run_start;
  logic              w_run_inc;

  always_comb begin
    w_kind = c_kind_lit;
    if (in_data == '0)
      w_kind = c_kind_zero;
    else if (&in_data)
      w_kind = c_kind_ones;
    else if (in_data[WIDTH-1:NARROW] == '0)
      w_kind = c_kind_zext;
    else if (in_data[WIDTH-1:NARROW] == {(WIDTH-NARROW){in_data[NARROW-1]}})
      w_kind = c_kind_sext;
  end

  assign w_is_fill   = (w_kind == c_kind_zero) || (w_kind == c_kind_ones);
  assign w_word_data = ((w_kind == c_kind_zext) || (w_kind == c_kind_sext)) ?
                       in_data[NARROW-1:0] : '0;
  assign w_word_lit  = (w_kind == c_kind_lit) ? in_data : '0;

  assign w_f       = !r_out_valid || out_ready;
  assign in_ready  = !rst && (r_state != c_st_pend) && w_f;
  assign w_accept  = in_valid && in_ready;
  assign w_same    = (w_kind == r_run_kind);
  assign w_cnt_inc = r_run_cnt + c_one;

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= c_st_idle;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_accept && w_is_fill && !in_last)
          w_state_nxt = c_st_run;
      end
      c_st_run: begin
        if (w_accept) begin
          if (w_same) begin
            if ((w_cnt_inc == c_rmax) || in_last)
              w_state_nxt = c_st_idle;
          end else if (!w_is_fill || in_last) begin
            w_state_nxt = c_st_pend;
          end
        end
      end
      c_st_pend: begin
        if (w_f)
          w_state_nxt = c_st_idle;
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_emit      = 1'b0;
    w_tok_kind  = w_kind;
    w_tok_cnt   = c_one;
    w_tok_data  = w_word_data;
    w_tok_lit   = w_word_lit;
    w_pend_load = 1'b0;
    w_run_start = 1'b0;
    w_run_inc   = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (w_accept) begin
          if (w_is_fill && !in_last)
            w_run_start = 1'b1;
          else
            w_emit = 1'b1;
        end
      end
      c_st_run: begin
        if (w_accept) begin
          w_tok_kind = r_run_kind;
          w_tok_data = '0;
          w_tok_lit  = '0;
          if (w_same) begin
            w_tok_cnt = w_cnt_inc;
            if ((w_cnt_inc == c_rmax) || in_last)
              w_emit = 1'b1;
            else
              w_run_inc = 1'b1;
          end else begin
            // Close the current run; the new word either parks or starts a run.
            w_emit    = 1'b1;
            w_tok_cnt = r_run_cnt;
            if (!w_is_fill || in_last)
              w_pend_load = 1'b1;
            else
              w_run_start = 1'b1;
          end
        end
      end
      c_st_pend: begin
        if (w_f) begin
          w_emit     = 1'b1;
          w_tok_kind = r_pend_kind;
          w_tok_cnt  = c_one;
          w_tok_data = r_pend_data;
          w_tok_lit  = r_pend_lit;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_kind  <= '0;
      r_out_count <= '0;
      r_out_data  <= '0;
      r_out_lit   <= '0;
      r_run_kind  <= '0;
      r_run_cnt   <= '0;
      r_pend_kind <= '0;
      r_pend_data <= '0;
      r_pend_lit  <= '0;
    end else begin
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_out_kind  <= w_tok_kind;
        r_out_count <= w_tok_cnt;
        r_out_data  <= w_tok_data;
        r_out_lit   <= w_tok_lit;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_run_start) begin
        r_run_kind <= w_kind;
        r_run_cnt  <= c_one;
      end else if (w_run_inc) begin
        r_run_cnt <= w_cnt_inc;
      end
      if (w_pend_load) begin
        r_pend_kind <= w_kind;
        r_pend_data <= w_word_data;
        r_pend_lit  <= w_word_lit;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_kind  = r_out_kind;
  assign out_count = r_out_count;
  assign out_data  = r_out_data;
  assign out_lit   = r_out_lit;

`ifdef FILL_RUN_ENCODER_STATS_EN
  logic [31:0] r_stat_words;
  logic [31:0] r_stat_tokens;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_words  <= '0;
      r_stat_tokens <= '0;
    end else begin
      if (w_accept && (r_stat_words != 32'hFFFF_FFFF))
        r_stat_words <= r_stat_words + 32'd1;
      if (r_out_valid && out_ready && (r_stat_tokens != 32'hFFFF_FFFF))
        r_stat_tokens <= r_stat_tokens + 32'd1;
    end
  end

  assign stat_words  = r_stat_words;
  assign stat_tokens = r_stat_tokens;
`endif

endmodule

`default_nettype wire

// File: doc/fill_run_encoder.md
Name: fill_run_encoder

Overview:
- Streaming encoder that compresses WIDTH-bit words into compact fill tokens.
- Token kinds: all-zeros, all-ones, zero-extended narrow literal, sign-extended narrow literal, full literal.
- Consecutive all-zeros or all-ones words are run-length merged into one token.
- Sits ahead of the fill-expansion stage that widens tokens back to full-width words; valid/ready on both sides.

Parameters:
- WIDTH, 40, data word width (must be > NARROW).
- NARROW, 2, width of the narrow literal carried in extension tokens.
- CNT_W, 8, run-count width; maximum run length is RMAX = 2^CNT_W-1.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  input word valid.
- in_ready  output  1  input word accepted when in_valid && in_ready.
- in_data  input  WIDTH  input word.
- in_last  input  1  end of stream; flushes any pending run.
- out_valid  output  1  token valid.
- out_ready  input  1  token accepted when out_valid && out_ready.
- out_kind  output  3  0=ZERO, 1=ONES, 2=ZEXT, 3=SEXT, 4=LIT.
- out_count  output  CNT_W  run length, 1..RMAX; always 1 for kinds 2-4.
- out_data  output  NARROW  low NARROW bits for ZEXT/SEXT, else 0.
- out_lit  output  WIDTH  full word for LIT, else 0.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Classification of in_data, first match wins:
  - ZERO: all bits 0.
  - ONES: all bits 1.
  - ZEXT: bits above NARROW-1 are 0.
  - SEXT: bits above NARROW-1 all equal bit NARROW-1.
  - LIT: anything else.
- Single output register. Define F = !out_valid || out_ready.
- States:
  - IDLE: nothing pending.
  - RUN: accumulator holds run kind r and count c.
  - PEND: one token waiting for the output register.
- in_ready = !rst && state != PEND && F (combinational).
- On accept, with k = class of in_data:
  - IDLE, k fill (ZERO/ONES), !in_last: go to RUN with (k,1).
  - IDLE, k fill with in_last, or k non-fill: emit (k,1) -> IDLE.
  - RUN, k==r: if c+1==RMAX or in_last, emit (r,c+1) -> IDLE; else c<=c+1.
  - RUN, k!=r: emit (r,c). New word goes to PEND if non-fill or in_last; otherwise to RUN with (k,1).
  - PEND: when F, load pending token into output -> IDLE; no input accepted that cycle.
- Latency: emitted token is visible on out_* the cycle after the triggering accept.
- While out_valid && !out_ready, all out_* are held stable.
- A run with no further input stays pending indefinitely; only in_last, a kind change or saturation flushes it.
- Reset values: out_valid=0, out_kind=0, out_count=0, out_data=0, out_lit=0, state=IDLE.
- Reset mid-run or in PEND discards the pending run/token; no partial token is emitted.

Optional Feature:
- Macro FILL_RUN_ENCODER_STATS_EN adds two outputs:
  - stat_words (32 bits): words accepted.
  - stat_tokens (32 bits): tokens accepted on the output.
- Both count saturating at 32'hFFFF_FFFF and reset to 0 on rst.
- Without the macro these ports and counters do not exist; all other behaviour is identical.

Test Plan:
Benches use WIDTH=40, NARROW=2, CNT_W=4 (RMAX=15), out_ready=1 unless stated.
1. 40'hFF_FFFF_FFFF x3, then 40'h0 with in_last -> tokens (ONES,3), then (ZERO,1); (ZERO,1) arrives via PEND.
2. 40'h2, 40'hFF_FFFF_FFFE, 40'h1, 40'h5, each with in_last -> (ZEXT,1,2'b10), (SEXT,1,2'b10), (ZEXT,1,2'b01), (LIT,1,out_lit=40'h5).
3. 20 zero words, in_last on the 20th -> (ZERO,15) the cycle after word 15, then (ZERO,5).
4. 4 ONES, then LIT 40'h12_3456_789A, out_ready low 3 cycles:
   - (ONES,4) held stable while stalled.
   - in_ready=0 during PEND.
   - then (LIT,1,40'h12_3456_789A).
5. 5 zero words, then rst for 1 cycle, then one zero word with in_last -> out_valid stays 0 through reset; only token is (ZERO,1).
6. STATS_EN build, scenario 1 -> stat_words=4, stat_tokens=2; after rst both 0.
